// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI bus arbiter: FSM encoding, index width and one-hot conversion.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int unsigned MAX_PORTS = 16;
    localparam int unsigned MAX_IDXW  = 4;
    localparam int unsigned GUARD_W   = 8;

    function automatic int unsigned idx_width(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [MAX_IDXW-1:0] idx);
        return MAX_PORTS'(1) << idx;
    endfunction

    function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] vec);
        logic [MAX_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (vec[i]) idx = idx | MAX_IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_pick.sv
// Rotating priority encoder: first set bit of eligible at or above rr_ptr, wrapping at PORTS-1.
module rr_priority_pick
    import spi_pkg::*;
#(
    parameter  int unsigned PORTS = 8,
    localparam int unsigned IDXW  = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] eligible,
    input  logic [IDXW-1:0]  rr_ptr,
    output logic             valid,
    output logic [IDXW-1:0]  winner
);

    localparam int unsigned SW = IDXW + 1;

    logic [2*PORTS-1:0] rotated;
    logic [SW-1:0]      sum;

    // Scan from the farthest offset down so the nearest eligible port is written last.
    always_comb begin
        rotated = {eligible, eligible} >> rr_ptr;
        valid   = 1'b0;
        winner  = '0;
        sum     = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = SW'(rr_ptr) + SW'(k);
                if (sum >= SW'(PORTS)) sum = sum - SW'(PORTS);
                valid  = 1'b1;
                winner = IDXW'(sum);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration of the shared SPI bus with a guard gap between owners and kernel lock.
module spi_bus_arbiter
    import spi_pkg::*;
#(
    parameter  int unsigned PORTS        = 8,
    parameter  int unsigned GUARD_CYCLES = 4,
    localparam int unsigned IDXW         = idx_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic [PORTS-1:0] req,
    input  logic             lock_en,
    input  logic [IDXW-1:0]  lock_port,
    output logic [PORTS-1:0] grant,
    output logic [PORTS-1:0] select,
    output logic             bus_en,
    output logic [IDXW-1:0]  owner,
    output logic             busy
);

    state_t               state;
    logic [IDXW-1:0]      rr_ptr;
    logic [GUARD_W-1:0]   guard_cnt;

    logic [PORTS-1:0]     mask_c;
    logic [PORTS-1:0]     eligible_c;
    logic                 pick_valid_c;
    logic [IDXW-1:0]      pick_idx_c;
    logic [PORTS-1:0]     winner_oh_c;
    logic [IDXW-1:0]      next_ptr_c;
    logic                 grant_now_c;

    // An out-of-range lock_port matches no bit, leaving the bus free.
    always_comb begin
        mask_c = '1;
        if (lock_en) begin
            mask_c = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (32'(lock_port) == 32'(i)) mask_c[i] = 1'b1;
            end
        end
    end

    assign eligible_c = req & mask_c;

    rr_priority_pick #(.PORTS(PORTS)) u_pick (
        .eligible (eligible_c),
        .rr_ptr   (rr_ptr),
        .valid    (pick_valid_c),
        .winner   (pick_idx_c)
    );

    assign winner_oh_c = PORTS'(idx_to_onehot(MAX_IDXW'(pick_idx_c)));
    assign next_ptr_c  = (owner == IDXW'(PORTS - 1)) ? '0 : owner + IDXW'(1);
    assign grant_now_c = pick_valid_c &&
                         ((state == ST_IDLE) || ((state == ST_GUARD) && (guard_cnt == '0)));

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state     <= ST_IDLE;
            grant     <= '0;
            select    <= '0;
            bus_en    <= 1'b0;
            owner     <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            guard_cnt <= '0;
        end else if (grant_now_c) begin
            state  <= ST_GRANT;
            grant  <= winner_oh_c;
            select <= winner_oh_c;
            owner  <= pick_idx_c;
            bus_en <= 1'b1;
            busy   <= 1'b1;
        end else begin
            case (state)
                // Ownership is co-operative: only the owner's own req drop ends it.
                ST_GRANT: begin
                    if (!req[owner]) begin
                        state     <= ST_GUARD;
                        grant     <= '0;
                        select    <= '0;
                        bus_en    <= 1'b0;
                        rr_ptr    <= next_ptr_c;
                        guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - GUARD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized and directed bench for spi_bus_arbiter against a cycle-level ownership model.
module tb_spi_bus_arbiter;

    localparam int P = 8;
    localparam int G = 4;

    logic         clk;
    logic         rst_L;
    logic [7:0]   req;
    logic         lock_en;
    logic [2:0]   lock_port;
    logic [7:0]   grant;
    logic [7:0]   select;
    logic         bus_en;
    logic [2:0]   owner;
    logic         busy;

    logic         s_rst_L;
    logic [4:0]   s_req;
    logic         s_lock_en;
    logic [2:0]   s_lock_port;
    logic [4:0]   s_grant;
    logic [4:0]   s_select;
    logic         s_bus_en;
    logic [2:0]   s_owner;
    logic         s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus, last owner, round-robin start, first cycle a new grant may happen.
    int m_owner, m_last, m_ptr, m_earliest, cyc;

    spi_bus_arbiter #(.PORTS(P), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst_L(rst_L), .req(req), .lock_en(lock_en), .lock_port(lock_port),
        .grant(grant), .select(select), .bus_en(bus_en), .owner(owner), .busy(busy)
    );

    spi_bus_arbiter #(.PORTS(5), .GUARD_CYCLES(2)) dut_small (
        .clk(clk), .rst_L(s_rst_L), .req(s_req), .lock_en(s_lock_en), .lock_port(s_lock_port),
        .grant(s_grant), .select(s_select), .bus_en(s_bus_en), .owner(s_owner), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic le, input logic [2:0] lp,
                                input int ptr);
        for (int k = 0; k < P; k++) begin
            int i = (ptr + k) % P;
            if (((r >> i) & 8'd1) != 8'd0 && (!le || int'(lp) == i)) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic le, input logic [2:0] lp,
                              input logic rn);
        int w;
        cyc++;
        if (!rn) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_earliest = cyc;
        end else if (m_owner >= 0) begin
            if ((r & (8'd1 << m_owner)) == 8'd0) begin
                m_ptr      = (m_owner + 1) % P;
                m_owner    = -1;
                m_earliest = cyc + G;
            end
        end else if (cyc >= m_earliest) begin
            w = pick(r, le, lp, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input logic [7:0] r, input logic le, input logic [2:0] lp, input logic rn);
        logic [7:0] exp_grant;
        req = r; lock_en = le; lock_port = lp; rst_L = rn;
        @(posedge clk);
        model_edge(r, le, lp, rn);
        @(negedge clk);
        exp_grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check_eq("grant",  32'(grant),  32'(exp_grant));
        check_eq("select", 32'(select), 32'(exp_grant));
        check_eq("bus_en", 32'(bus_en), 32'(m_owner >= 0));
        check_eq("owner",  32'(owner),  32'(m_last));
        check_eq("busy",   32'(busy),   32'((m_owner >= 0) || (cyc < m_earliest)));
        check_eq("onehot0_grant", 32'($onehot0(grant)), 32'd1);
        check_eq("select_eq_grant", 32'(select == grant), 32'd1);
        check_eq("bus_en_needs_grant", 32'(!bus_en || (|grant)), 32'd1);
    endtask

    logic [7:0] rq, r3;
    logic       le;
    logic [2:0] lp;
    int cur, held, ngr, exp_next, gi, zeros;

    initial begin
        m_owner = -1; m_last = 0; m_ptr = 0; m_earliest = 0; cyc = 0;
        s_rst_L = 1'b0; s_req = 5'h1F; s_lock_en = 1'b1; s_lock_port = 3'd6;

        // Reset state
        step(8'h00, 1'b0, 3'd0, 1'b0);
        check_eq("reset_grant", 32'(grant), 32'd0);
        check_eq("reset_busy",  32'(busy),  32'd0);
        step(8'h00, 1'b0, 3'd0, 1'b1);

        // Single request: granted one clock later
        step(8'h04, 1'b0, 3'd0, 1'b1);
        check_eq("t1_grant", 32'(grant), 32'h04);
        check_eq("t1_owner", 32'(owner), 32'd2);
        check_eq("t1_bus_en", 32'(bus_en), 32'd1);
        step(8'h04, 1'b0, 3'd0, 1'b1);

        // Owner 2 releases with ports 0 and 3 pending: guard, then port 3
        for (int i = 0; i < G; i++) begin
            step(8'h09, 1'b0, 3'd0, 1'b1);
            check_eq("t2_guard_grant", 32'(grant), 32'd0);
        end
        step(8'h09, 1'b0, 3'd0, 1'b1);
        check_eq("t2_next_grant", 32'(grant), 32'h08);

        // All ports requesting, each owner holds three clocks
        step(8'h00, 1'b0, 3'd0, 1'b0);
        cur = -1; held = 0; ngr = 0; exp_next = 0; zeros = -1;
        for (int c = 0; c < 200 && ngr < 9; c++) begin
            r3 = 8'hFF;
            if (held == 3) r3 = r3 & ~(8'd1 << cur);
            step(r3, 1'b0, 3'd0, 1'b1);
            if (|grant) begin
                gi = 0;
                for (int i = 0; i < P; i++) if (grant[i]) gi = i;
                if (gi != cur) begin
                    check_eq("t3_rr_order", 32'(gi), 32'(exp_next));
                    if (zeros >= 0) check_eq("t3_gap", 32'(zeros), 32'(G));
                    exp_next = (exp_next + 1) % P;
                    ngr++; cur = gi; held = 1; zeros = 0;
                end else begin
                    held++;
                end
            end else begin
                cur = -1; held = 0;
                if (zeros >= 0) zeros++;
            end
        end
        check_eq("t3_grant_count", 32'(ngr), 32'd9);

        // Lock to port 5; small instance shows an out-of-range lock keeps the bus free
        step(8'h00, 1'b1, 3'd5, 1'b0);
        s_rst_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(8'hFF, 1'b1, 3'd5, 1'b1);
            check_eq("t4_lock_only5", 32'(grant & 8'hDF), 32'd0);
            check_eq("t4_small_no_grant", 32'(s_grant), 32'd0);
            check_eq("t4_small_bus_en", 32'(s_bus_en), 32'd0);
        end
        check_eq("t4_lock5_granted", 32'(grant), 32'h20);
        s_lock_port = 3'd3;
        step(8'hFF, 1'b1, 3'd5, 1'b1);
        check_eq("t4_small_lock3", 32'(s_grant), 32'h08);

        // Lock arriving mid-ownership does not pre-empt
        step(8'h00, 1'b0, 3'd0, 1'b0);
        step(8'h02, 1'b0, 3'd0, 1'b1);
        check_eq("t5_owner1", 32'(grant), 32'h02);
        for (int i = 0; i < 4; i++) begin
            step(8'h42, 1'b1, 3'd6, 1'b1);
            check_eq("t5_keep1", 32'(grant), 32'h02);
        end
        for (int i = 0; i < G; i++) begin
            step(8'h40, 1'b1, 3'd6, 1'b1);
            check_eq("t5_guard", 32'(grant), 32'd0);
        end
        step(8'h40, 1'b1, 3'd6, 1'b1);
        check_eq("t5_port6", 32'(grant), 32'h40);

        // Reset during GRANT, then immediate grant to lowest requester
        step(8'h30, 1'b0, 3'd0, 1'b0);
        check_eq("t6_grant", 32'(grant), 32'd0);
        check_eq("t6_bus_en", 32'(bus_en), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        step(8'h30, 1'b0, 3'd0, 1'b1);
        check_eq("t6_regrant", 32'(grant), 32'h10);

        // Random traffic
        rq = 8'h00; le = 1'b0; lp = 3'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < P; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(3) == 0) rq[i] = 1'b0;
                end else if (!rq[i]) begin
                    if ($urandom_range(2) == 0) rq[i] = 1'b1;
                end else if ($urandom_range(15) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            if ($urandom_range(31) == 0) le = ~le;
            if ($urandom_range(15) == 0) lp = 3'($urandom_range(7));
            step(rq, le, lp, ($urandom_range(127) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
